ffd_piso_register: RTL and testbench

FFD_PISO_REGISTER -- requirements
Module: ffd_piso_register

---
 rtl/ffd_piso_register.sv | 54 +++++
 tb/tb_ffd_piso_register.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ffd_piso_register.sv
// 4-bit parallel-in / serial-out register built from D flip-flops, with a per-bit
// load/shift mux and a clock-enable divider that advances the register once every DIV_N cycles.
module ffd_piso_register #(
  parameter int unsigned DIV_N = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] d_i,
  input  logic       serialin_i,
  input  logic       move_load_i,
  output logic       q_o,
  output logic [3:0] q_par_o
);

  localparam int unsigned CW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV_N - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    r;
  logic [3:0]    r_next;

  // With DIV_N=1 the terminal count is 0, so the counter sits at 0 and tick stays high.
  assign tick = (cnt == TC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    r_next[3] = move_load_i ? serialin_i : d_i[3];
    r_next[2] = move_load_i ? r[3]       : d_i[2];
    r_next[1] = move_load_i ? r[2]       : d_i[1];
    r_next[0] = move_load_i ? r[1]       : d_i[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r <= 4'b0000;
    end else if (tick) begin
      r <= r_next;
    end
  end

  assign q_o     = r[0];
  assign q_par_o = r;

endmodule

// File: tb/tb_ffd_piso_register.sv
// Scoreboard bench for ffd_piso_register: one instance with DIV_N=1, one with DIV_N=4.
module tb_ffd_piso_register;

  logic       clk = 1'b0;
  logic       rst1, s1, m1;
  logic [3:0] d1;
  logic       q1;
  logic [3:0] p1;
  logic       rst4, s4, m4;
  logic [3:0] d4;
  logic       q4;
  logic [3:0] p4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    bit         dut4;
    logic [3:0] par;
    string      nm;
  } exp_t;

  exp_t sb[$];

  ffd_piso_register #(.DIV_N(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .d_i(d1), .serialin_i(s1), .move_load_i(m1),
    .q_o(q1), .q_par_o(p1)
  );

  ffd_piso_register #(.DIV_N(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .d_i(d4), .serialin_i(s4), .move_load_i(m4),
    .q_o(q4), .q_par_o(p4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic       aq;
      logic [3:0] ap;
      e  = sb.pop_front();
      aq = e.dut4 ? q4 : q1;
      ap = e.dut4 ? p4 : p1;
      n_checks += 2;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.nm, e.cyc, cyc);
      end
      if (ap !== e.par) begin
        n_fail++;
        $display("FAIL %s q_par: got %b required %b (cycle %0d)", e.nm, ap, e.par, cyc);
      end
      if (aq !== e.par[0]) begin
        n_fail++;
        $display("FAIL %s q_o: got %b required %b (cycle %0d)", e.nm, aq, e.par[0], cyc);
      end
    end
  end

  task automatic step1(input logic rst, input logic [3:0] d, input logic s, input logic m,
                       input logic [3:0] ex, input string nm);
    exp_t e;
    rst1 = rst; d1 = d; s1 = s; m1 = m;
    e.cyc = cyc + 1; e.dut4 = 1'b0; e.par = ex; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic step4(input logic rst, input logic [3:0] d, input logic s, input logic m,
                       input logic [3:0] ex, input string nm);
    exp_t e;
    rst4 = rst; d4 = d; s4 = s; m4 = m;
    e.cyc = cyc + 1; e.dut4 = 1'b1; e.par = ex; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; d1 = 4'hF; s1 = 1'b0; m1 = 1'b0;
    rst4 = 1'b1; d4 = 4'h0; s4 = 1'b0; m4 = 1'b0;
    @(posedge clk); #2;

    // DIV_N=1: reset with load data present
    step1(1, 4'hF, 0, 0, 4'b0000, "rst_a");
    step1(1, 4'hF, 0, 0, 4'b0000, "rst_b");
    // load 1011 then shift zeros in; d_i must be ignored while shifting
    step1(0, 4'b1011, 0, 0, 4'b1011, "load");
    step1(0, 4'b0110, 0, 1, 4'b0101, "shf1");
    step1(0, 4'b0110, 0, 1, 4'b0010, "shf2");
    step1(0, 4'b0110, 0, 1, 4'b0001, "shf3");
    step1(0, 4'b0110, 0, 1, 4'b0000, "shf4");
    // serial-in pattern 1,0,0,1 after reset
    step1(1, 4'hF, 1, 1, 4'b0000, "rst_c");
    step1(0, 4'h0, 1, 1, 4'b1000, "ser1");
    step1(0, 4'h0, 0, 1, 4'b0100, "ser2");
    step1(0, 4'h0, 0, 1, 4'b0010, "ser3");
    step1(0, 4'h0, 1, 1, 4'b1001, "ser4");
    // continuous loads follow d_i each tick
    step1(0, 4'b0110, 0, 0, 4'b0110, "cld1");
    step1(0, 4'b0101, 0, 0, 4'b0101, "cld2");
    // reset mid-shift discards contents, then shifting resumes
    step1(0, 4'b1111, 0, 0, 4'b1111, "ld_f");
    step1(0, 4'b0000, 1, 1, 4'b1111, "rs1");
    step1(0, 4'b0000, 1, 1, 4'b1111, "rs2");
    step1(1, 4'b1111, 1, 1, 4'b0000, "rst_mid");
    step1(0, 4'b0000, 1, 1, 4'b1000, "rs3");
    step1(0, 4'b0000, 1, 1, 4'b1100, "rs4");
    step1(0, 4'b0000, 1, 1, 4'b1110, "rs5");
    step1(0, 4'b0000, 1, 1, 4'b1111, "rs6");
    rst1 = 1'b1;

    // DIV_N=4: inputs toggle between ticks and must have no effect
    step4(1, 4'hF, 1, 0, 4'b0000, "d4_rst");
    step4(0, 4'b1010, 1, 1, 4'b0000, "d4_h1");
    step4(0, 4'b0111, 0, 0, 4'b0000, "d4_h2");
    step4(0, 4'b1100, 1, 1, 4'b0000, "d4_h3");
    step4(0, 4'b0001, 0, 0, 4'b0001, "d4_load");
    step4(0, 4'b1110, 0, 0, 4'b0001, "d4_h4");
    step4(0, 4'b0000, 1, 1, 4'b0001, "d4_h5");
    step4(0, 4'b1010, 0, 0, 4'b0001, "d4_h6");
    step4(0, 4'b1111, 0, 1, 4'b0000, "d4_shf1");
    step4(0, 4'b1111, 1, 0, 4'b0000, "d4_h7");
    step4(0, 4'b0101, 1, 1, 4'b0000, "d4_h8");
    step4(0, 4'b1111, 0, 0, 4'b0000, "d4_h9");
    step4(0, 4'b0000, 1, 1, 4'b1000, "d4_shf2");
    step4(0, 4'b0011, 0, 0, 4'b1000, "d4_h10");
    // reset restarts the divider: next tick is on the 4th edge after release
    step4(1, 4'b1111, 0, 0, 4'b0000, "d4_rst2");
    step4(0, 4'b1111, 0, 0, 4'b0000, "d4_h11");
    step4(0, 4'b1111, 0, 0, 4'b0000, "d4_h12");
    step4(0, 4'b1111, 0, 0, 4'b0000, "d4_h13");
    step4(0, 4'b1111, 0, 0, 4'b1111, "d4_ld2");

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
